// File: rtl/halve_tokens_pkg.sv
// Shared types and defaults for the halve_tokens pair decoder.
package halve_tokens_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HALF,
        FULL
    } state_t;

    localparam int unsigned MAX_TOKENS_DEFAULT = 200;

endpackage

// File: rtl/halve_tokens_if.sv
// Serial stream and status flags of the halve_tokens decoder.
interface halve_tokens_if;

    logic a;
    logic b;
    logic odd_run;
    logic overflow;

    modport master (output a, input b, input odd_run, input overflow);
    modport slave  (input a, output b, output odd_run, output overflow);

endinterface

// File: rtl/halve_tokens_run_counter.sv
// Saturating count of consecutive ones with a sticky overflow flag.
module halve_tokens_run_counter
    import halve_tokens_pkg::*;
#(
    parameter int unsigned MAX_TOKENS = MAX_TOKENS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic overflow
);

    localparam int unsigned CW = $clog2(2 * MAX_TOKENS + 2);
    localparam logic [CW-1:0] LIMIT = CW'(2 * MAX_TOKENS);
    localparam logic [CW-1:0] SAT   = CW'(2 * MAX_TOKENS + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (!a) begin
                count <= '0;
            end else if (count != SAT) begin
                count <= count + 1'b1;
            end
            // count holds the ones before this sample, so LIMIT means this is one past the limit
            if (a && count >= LIMIT) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/halve_tokens.sv
// Halves a doubled serial stream: one b pulse per pair of input ones.
// Define HALVE_TOKENS_STRICT_EN to flag odd runs instead of rounding them up.
module halve_tokens
    import halve_tokens_pkg::*;
#(
    parameter int unsigned MAX_TOKENS = MAX_TOKENS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    halve_tokens_if.slave  bus
);

    state_t state;
    logic   b_q;

    halve_tokens_run_counter #(
        .MAX_TOKENS (MAX_TOKENS)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .a        (bus.a),
        .overflow (bus.overflow)
    );

`ifdef HALVE_TOKENS_STRICT_EN
    logic odd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            odd_q <= 1'b0;
        end else if (state == HALF && !bus.a) begin
            odd_q <= 1'b1;
        end
    end

    assign bus.odd_run = odd_q;
`else
    assign bus.odd_run = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            b_q   <= 1'b0;
        end else begin
            b_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.a) state <= HALF;
                end
                HALF: begin
                    if (bus.a) begin
                        state <= FULL;
                        b_q   <= 1'b1;
                    end else begin
                        state <= IDLE;
`ifndef HALVE_TOKENS_STRICT_EN
                        // trailing half token rounds up to a full output token
                        b_q   <= 1'b1;
`endif
                    end
                end
                FULL: begin
                    state <= bus.a ? HALF : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.b = b_q;

endmodule

// File: tb/tb_halve_tokens.sv
// Scoreboard bench for halve_tokens: driver queues expected flags, monitor compares after each edge.
module tb_halve_tokens;

`ifdef HALVE_TOKENS_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        logic  b;
        logic  odd;
        logic  ovf;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    int   b_count = 0;
    exp_t sb[$];

    halve_tokens_if bus ();

    halve_tokens #(
        .MAX_TOKENS (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic av, input logic eb, input logic eo, input logic ev, input string tag);
        exp_t e;
        @(negedge clk);
        bus.a = av;
        e.b = eb; e.odd = eo; e.ovf = ev; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b0;
        bus.a = 1'b1;
        #2;
        chk({tag, "_rst_b"},   bus.b,        1'b0);
        chk({tag, "_rst_odd"}, bus.odd_run,  1'b0);
        chk({tag, "_rst_ovf"}, bus.overflow, 1'b0);
        repeat (2) @(negedge clk);
        chk({tag, "_rsthold_b"}, bus.b, 1'b0);
        rst   = 1'b1;
        bus.a = 1'b0;
        b_count = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk({tag, "_drained"}, sb.size() == 0, 1'b1);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (bus.b === 1'b1) b_count++;
                chk({e.tag, "_b"},   bus.b,        e.b);
                chk({e.tag, "_odd"}, bus.odd_run,  e.odd);
                chk({e.tag, "_ovf"}, bus.overflow, e.ovf);
            end
        end
    end

    initial begin : driver
        logic av [9];
        logic eb [9];
        av = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.a = 1'b0;

        // pairs and a four-one run: b in cycles 3, 6, 8
        do_reset("pairs");
        for (int i = 0; i < 9; i++) step(av[i], eb[i], 1'b0, 1'b0, "pairs");
        drain("pairs");

        // single one then zero: odd flag (strict) or rounded-up token
        do_reset("odd");
        step(1'b1, 1'b0, 1'b0, 1'b0, "odd_one");
        step(1'b0, !STRICT, STRICT, 1'b0, "odd_end");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, STRICT, 1'b0, "odd_idle");
        drain("odd");

        // exactly 400 ones: 200 pulses, no overflow
        do_reset("r400");
        for (int k = 1; k <= 400; k++) step(1'b1, (k % 2) == 0, 1'b0, 1'b0, "r400");
        step(1'b0, 1'b0, 1'b0, 1'b0, "r400_end");
        drain("r400");
        chk("r400_pulses", b_count == 200, 1'b1);

        // 401 ones: overflow right after the 401st, sticky through the odd tail
        do_reset("r401");
        for (int k = 1; k <= 401; k++) step(1'b1, (k % 2) == 0, 1'b0, k == 401, "r401");
        step(1'b1, 1'b1, 1'b0, 1'b1, "r401_sat");
        step(1'b1, 1'b0, 1'b0, 1'b1, "r401_sat2");
        step(1'b0, !STRICT, STRICT, 1'b1, "r401_end");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, STRICT, 1'b1, "r401_idle");
        drain("r401");

        // reset mid-run discards the pending half pair
        do_reset("mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, "mid_pre1");
        step(1'b1, 1'b1, 1'b0, 1'b0, "mid_pre2");
        step(1'b1, 1'b0, 1'b0, 1'b0, "mid_pre3");
        drain("mid_pre");
        do_reset("mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, "mid_post1");
        step(1'b1, 1'b1, 1'b0, 1'b0, "mid_post2");
        step(1'b0, 1'b0, 1'b0, 1'b0, "mid_post_end");
        step(1'b0, 1'b0, 1'b0, 1'b0, "mid_post_idle");
        drain("mid_post");
        chk("mid_pulses", b_count == 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
